// File: rtl/dir_write_pipe.sv
// Directory write pipeline: DEPTH-stage elastic pipe with bubble collapse, flush,
// and a same-set hazard query that forwards the youngest matching in-flight entry.
module dir_write_pipe #(
  parameter int DEPTH   = 3,
  parameter int SET_W   = 7,
  parameter int WAY_W   = 4,
  parameter int STATE_W = 2,
  parameter int NCH     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_in_valid,
  output logic                         io_in_ready,
  input  logic [SET_W-1:0]             io_in_bits_set,
  input  logic [WAY_W-1:0]             io_in_bits_way,
  input  logic [NCH*STATE_W-1:0]       io_in_bits_data_state,
  output logic                         io_out_valid,
  input  logic                         io_out_ready,
  output logic [SET_W-1:0]             io_out_bits_set,
  output logic [WAY_W-1:0]             io_out_bits_way,
  output logic [NCH*STATE_W-1:0]       io_out_bits_data_state,
  input  logic                         io_flush,
  input  logic [SET_W-1:0]             io_query_set,
  output logic                         io_query_hit,
  output logic [WAY_W-1:0]             io_query_way,
  output logic [NCH*STATE_W-1:0]       io_query_state,
  output logic [$clog2(DEPTH+1)-1:0]   io_count
);

  localparam int SW    = NCH * STATE_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] rdy;
  logic [SET_W-1:0] set_q [DEPTH];
  logic [WAY_W-1:0] way_q [DEPTH];
  logic [SW-1:0]    st_q  [DEPTH];
  logic             in_fire;

  // A stage is ready when empty or when its own entry moves on, so bubbles collapse.
  always_comb begin
    adv = '0;
    rdy = '0;
    adv[DEPTH-1] = v[DEPTH-1] & io_out_ready;
    rdy[DEPTH-1] = ~v[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = v[i] & rdy[i+1];
      rdy[i] = ~v[i] | adv[i];
    end
  end

  assign io_in_ready            = rdy[0] & ~io_flush;
  assign in_fire                = io_in_valid & io_in_ready;
  assign io_out_valid           = v[DEPTH-1] & ~io_flush;
  assign io_out_bits_set        = set_q[DEPTH-1];
  assign io_out_bits_way        = way_q[DEPTH-1];
  assign io_out_bits_data_state = st_q[DEPTH-1];

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      v <= '0;
    end else begin
      v[0] <= in_fire | (v[0] & ~adv[0]);
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= adv[i-1] | (v[i] & ~adv[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) begin
      set_q[0] <= io_in_bits_set;
      way_q[0] <= io_in_bits_way;
      st_q[0]  <= io_in_bits_data_state;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        set_q[i] <= set_q[i-1];
        way_q[i] <= way_q[i-1];
        st_q[i]  <= st_q[i-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match (input fire last) wins.
  always_comb begin
    io_query_hit   = 1'b0;
    io_query_way   = '0;
    io_query_state = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i] && (set_q[i] == io_query_set)) begin
        io_query_hit   = 1'b1;
        io_query_way   = way_q[i];
        io_query_state = st_q[i];
      end
    end
    if (in_fire && (io_in_bits_set == io_query_set)) begin
      io_query_hit   = 1'b1;
      io_query_way   = io_in_bits_way;
      io_query_state = io_in_bits_data_state;
    end
  end

  always_comb begin
    io_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      io_count = io_count + CNT_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_dir_write_pipe.sv
// Scoreboard bench for dir_write_pipe: the reference model is an ordered queue of
// in-flight entries; a monitor checks count, readiness, query and output each cycle.
module tb_dir_write_pipe;

  localparam int DEPTH   = 3;
  localparam int SET_W   = 7;
  localparam int WAY_W   = 4;
  localparam int STATE_W = 2;
  localparam int NCH     = 2;
  localparam int SW      = NCH * STATE_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [SET_W-1:0] io_in_bits_set = '0;
  logic [WAY_W-1:0] io_in_bits_way = '0;
  logic [SW-1:0]    io_in_bits_data_state = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [SET_W-1:0] io_out_bits_set;
  logic [WAY_W-1:0] io_out_bits_way;
  logic [SW-1:0]    io_out_bits_data_state;
  logic             io_flush = 1'b0;
  logic [SET_W-1:0] io_query_set = '0;
  logic             io_query_hit;
  logic [WAY_W-1:0] io_query_way;
  logic [SW-1:0]    io_query_state;
  logic [CNT_W-1:0] io_count;

  dir_write_pipe #(
    .DEPTH(DEPTH), .SET_W(SET_W), .WAY_W(WAY_W), .STATE_W(STATE_W), .NCH(NCH)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_set(io_in_bits_set), .io_in_bits_way(io_in_bits_way),
    .io_in_bits_data_state(io_in_bits_data_state),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_set(io_out_bits_set), .io_out_bits_way(io_out_bits_way),
    .io_out_bits_data_state(io_out_bits_data_state),
    .io_flush(io_flush), .io_query_set(io_query_set),
    .io_query_hit(io_query_hit), .io_query_way(io_query_way),
    .io_query_state(io_query_state), .io_count(io_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [SET_W-1:0] set;
    logic [WAY_W-1:0] way;
    logic [SW-1:0]    st;
    int               cyc;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   pushed_now = 1'b0;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs; an accepted entry becomes the model's youngest.
  task automatic applyStimulus(input bit rst, input bit vld, input logic [SET_W-1:0] s,
                               input logic [WAY_W-1:0] w, input logic [SW-1:0] st,
                               input bit ordy, input bit fl, input logic [SET_W-1:0] qs);
    @(negedge clock);
    reset                 = rst;
    io_in_valid           = vld;
    io_in_bits_set        = s;
    io_in_bits_way        = w;
    io_in_bits_data_state = st;
    io_out_ready          = ordy;
    io_flush              = fl;
    io_query_set          = qs;
    pushed_now            = 1'b0;
    #1;
    if (!rst && io_in_valid && io_in_ready) begin
      sb.push_back('{s, w, st, cyc});
      pushed_now = 1'b1;
    end
  endtask

  task automatic idle(input bit ordy, input logic [SET_W-1:0] qs);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, ordy, 1'b0, qs);
  endtask

  task automatic monitorStep();
    int               cnt_reg;
    bit               found;
    logic [WAY_W-1:0] ew;
    logic [SW-1:0]    es;
    if (reset) begin
      sb.delete();
      return;
    end
    cnt_reg = sb.size() - (pushed_now ? 1 : 0);
    checkOutput("count", 32'(io_count), cnt_reg);
    checkOutput("in_ready", 32'(io_in_ready),
                32'(!io_flush && ((cnt_reg < DEPTH) || io_out_ready)));
    found = 1'b0;
    ew    = '0;
    es    = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (!found && (sb[i].set == io_query_set)) begin
        found = 1'b1;
        ew    = sb[i].way;
        es    = sb[i].st;
      end
    end
    checkOutput("query_hit", 32'(io_query_hit), 32'(found));
    checkOutput("query_way", 32'(io_query_way), 32'(ew));
    checkOutput("query_state", 32'(io_query_state), 32'(es));
    if (io_flush || cnt_reg == 0) begin
      checkOutput("out_valid_idle", 32'(io_out_valid), 0);
    end else begin
      if (cnt_reg == DEPTH) checkOutput("out_valid_full", 32'(io_out_valid), 1);
      if (io_out_valid) begin
        checkOutput("out_age", 32'((cyc - sb[0].cyc) >= DEPTH), 1);
        checkOutput("out_set", 32'(io_out_bits_set), 32'(sb[0].set));
        checkOutput("out_way", 32'(io_out_bits_way), 32'(sb[0].way));
        checkOutput("out_state", 32'(io_out_bits_data_state), 32'(sb[0].st));
        if (io_out_ready) void'(sb.pop_front());
      end
    end
    if (io_flush) sb.delete();
  endtask

  always @(negedge clock) begin
    #2;
    if (mon_en) monitorStep();
  end

  initial begin
    int rdy_pct;
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    mon_en = 1'b1;

    idle(1'b1, 7'h05);
    checkOutput("rst_out_valid", 32'(io_out_valid), 0);
    checkOutput("rst_count", 32'(io_count), 0);
    checkOutput("rst_query_hit", 32'(io_query_hit), 0);
    checkOutput("rst_in_ready", 32'(io_in_ready), 1);

    // Single entry, unstalled: output appears DEPTH cycles after the fire.
    applyStimulus(1'b0, 1'b1, 7'h05, 4'h3, {2'd2, 2'd1}, 1'b1, 1'b0, 7'h7f);
    for (int k = 1; k <= 3; k++) begin
      idle(1'b1, 7'h7f);
      checkOutput("lat_count", 32'(io_count), 1);
      checkOutput("lat_valid", 32'(io_out_valid), 32'(k == 3));
    end
    checkOutput("lat_set", 32'(io_out_bits_set), 32'h05);
    checkOutput("lat_way", 32'(io_out_bits_way), 32'h3);
    checkOutput("lat_state", 32'(io_out_bits_data_state), 32'h9);

    // Backpressure: three accepts fill the pipe, then release in order.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 7'(7'h40 + k), 4'(k), 4'(k), 1'b0, 1'b0, 7'h7f);
      checkOutput("bp_ready", 32'(io_in_ready), 32'(k < 3));
      checkOutput("bp_count", 32'(io_count), (k < 3) ? k : 3);
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 7'h7f);
      checkOutput("bp_out_valid", 32'(io_out_valid), 1);
      checkOutput("bp_out_set", 32'(io_out_bits_set), 32'(7'h40 + k));
    end
    idle(1'b1, 7'h7f);

    // Two entries with the same set: the younger way is forwarded.
    applyStimulus(1'b0, 1'b1, 7'h10, 4'h1, 4'h0, 1'b0, 1'b0, 7'h7f);
    applyStimulus(1'b0, 1'b1, 7'h33, 4'h5, 4'h0, 1'b0, 1'b0, 7'h7f);
    applyStimulus(1'b0, 1'b1, 7'h10, 4'h2, 4'h0, 1'b0, 1'b0, 7'h7f);
    idle(1'b0, 7'h10);
    checkOutput("haz_count", 32'(io_count), 3);
    checkOutput("haz_hit", 32'(io_query_hit), 1);
    checkOutput("haz_way", 32'(io_query_way), 2);
    idle(1'b0, 7'h11);
    checkOutput("haz_miss_hit", 32'(io_query_hit), 0);
    checkOutput("haz_miss_way", 32'(io_query_way), 0);
    repeat (4) idle(1'b1, 7'h7f);

    // Same-cycle input fire is visible to the query.
    applyStimulus(1'b0, 1'b1, 7'h20, 4'h9, 4'hc, 1'b1, 1'b0, 7'h20);
    checkOutput("fwd_in_ready", 32'(io_in_ready), 1);
    checkOutput("fwd_hit", 32'(io_query_hit), 1);
    checkOutput("fwd_way", 32'(io_query_way), 32'h9);
    checkOutput("fwd_state", 32'(io_query_state), 32'hc);
    repeat (4) idle(1'b1, 7'h7f);

    // Flush with a full pipe and an offered input.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b1, 7'(7'h50 + k), 4'(k), 4'(k), 1'b0, 1'b0, 7'h7f);
    applyStimulus(1'b0, 1'b1, 7'h60, 4'h1, 4'h1, 1'b1, 1'b1, 7'h7f);
    checkOutput("flush_in_ready", 32'(io_in_ready), 0);
    checkOutput("flush_out_valid", 32'(io_out_valid), 0);
    idle(1'b1, 7'h7f);
    checkOutput("flush_count", 32'(io_count), 0);
    checkOutput("flush_out_valid_next", 32'(io_out_valid), 0);

    // Mid-operation reset with two entries in flight.
    applyStimulus(1'b0, 1'b1, 7'h70, 4'h1, 4'h1, 1'b0, 1'b0, 7'h7f);
    applyStimulus(1'b0, 1'b1, 7'h71, 4'h2, 4'h2, 1'b0, 1'b0, 7'h7f);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 7'h7f);
    idle(1'b0, 7'h70);
    checkOutput("mrst_count", 32'(io_count), 0);
    checkOutput("mrst_out_valid", 32'(io_out_valid), 0);
    checkOutput("mrst_in_ready", 32'(io_in_ready), 1);

    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 60 == 0) rdy_pct = $urandom_range(0, 100);
      applyStimulus($urandom_range(0, 149) == 0,
                    $urandom_range(0, 3) != 0,
                    7'($urandom_range(0, 7)),
                    4'($urandom),
                    4'($urandom),
                    $urandom_range(0, 99) < rdy_pct,
                    $urandom_range(0, 49) == 0,
                    7'($urandom_range(0, 7)));
    end

    repeat (DEPTH + 2) idle(1'b1, 7'h7f);
    checkOutput("drain_count", 32'(io_count), 0);
    #5;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
